// File: rtl/pc_sequencer.sv
// pc_sequencer: PC-update sequencer and return-address stack for the multi-cycle core.
// Turns an update request from the control unit into a registered PCSrc select plus a
// one-cycle pc_write strobe, and owns the RAS (CALL pushes pc_cur+1, RET pops).
// Optional feature macro: PCSEQ_RAS_WRAP_EN (circular RAS, CALL on full overwrites oldest).
// Without the macro, a CALL on a full RAS halts the sequencer with err_ovf set.
//
// Handshake: upd_req is accepted only in the cycle the sequencer is idle (busy=0); the
// control unit must not expect anything from upd_req while busy=1, since nothing is queued.
// An accepted request produces pc_write=1 exactly one clock later, unless it is a RAS error,
// in which case the sequencer goes to HALT, pc_write stays low, and it waits for clr_err.
module pc_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_req,
  input  logic                    is_jump,
  input  logic                    is_call,
  input  logic                    is_ret,
  input  logic                    br_taken,
  input  logic [AW-1:0]           pc_cur,
  input  logic                    clr_err,
  output logic [1:0]              pc_src,
  output logic                    pc_write,
  output logic [AW-1:0]           top_address,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  ras_count,
  output logic                    ras_full,
  output logic                    ras_empty,
  output logic                    err_ovf,
  output logic                    err_unf,
  output logic [1:0]              dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] SRC_SEQ = 2'b00;
  localparam logic [1:0] SRC_JMP = 2'b01;
  localparam logic [1:0] SRC_BR  = 2'b10;
  localparam logic [1:0] SRC_RET = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } op_t;

  state_t          state_q, state_d;
  op_t             dec_op;
  logic [1:0]      dec_src;
  op_t             op_q;
  logic [1:0]      src_q;
  logic [AW-1:0]   ret_addr_q;

  logic [AW-1:0]   ras_q [DEPTH];
  logic [PW-1:0]   sp_q, sp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   top_idx;

  logic            err_unf_q, err_unf_d;
  logic            accept;
  logic            unf_hit;
  logic            ovf_hit;
  logic            ras_err;
  logic            commit_push;
  logic            commit_pop;

  // Decode the update request; RET beats CALL beats JUMP beats branch beats sequential.
  always_comb begin
    dec_src = SRC_SEQ;
    dec_op  = OP_NONE;
    if (is_ret) begin
      dec_src = SRC_RET;
      dec_op  = OP_POP;
    end else if (is_call) begin
      dec_src = SRC_JMP;
      dec_op  = OP_PUSH;
    end else if (is_jump) begin
      dec_src = SRC_JMP;
    end else if (br_taken) begin
      dec_src = SRC_BR;
    end
  end

  assign ras_full  = (cnt_q == CW'(DEPTH));
  assign ras_empty = (cnt_q == '0);
  assign ras_count = cnt_q;

  assign accept  = (state_q == ST_IDLE) && upd_req;
  assign unf_hit = accept && (dec_op == OP_POP) && ras_empty;
`ifdef PCSEQ_RAS_WRAP_EN
  assign ovf_hit = 1'b0;
`else
  assign ovf_hit = accept && (dec_op == OP_PUSH) && ras_full;
`endif
  assign ras_err = unf_hit | ovf_hit;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: an erroring request goes straight to HALT and never produces pc_write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ras_err ? ST_HALT : ST_UPDATE;
      end
      ST_UPDATE: state_d = ST_IDLE;
      ST_HALT: begin
        if (clr_err) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; pc_src is forced to 00 outside the strobe cycle.
  always_comb begin
    pc_write  = 1'b0;
    pc_src    = SRC_SEQ;
    busy      = (state_q != ST_IDLE);
    dbg_state = state_q;
    if (state_q == ST_UPDATE) begin
      pc_write = 1'b1;
      pc_src   = src_q;
    end
  end

  // Capture the decoded request at the accept edge for use in the UPDATE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_NONE;
      src_q      <= SRC_SEQ;
      ret_addr_q <= '0;
    end else if (accept && !ras_err) begin
      op_q       <= dec_op;
      src_q      <= dec_src;
      ret_addr_q <= pc_cur + AW'(1);
    end
  end

  assign commit_push = (state_q == ST_UPDATE) && (op_q == OP_PUSH);
  assign commit_pop  = (state_q == ST_UPDATE) && (op_q == OP_POP);

  // Stack pointer/count update; a push on a full stack only happens in the wrap build,
  // where the pointer advances over the oldest entry and the count saturates.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (commit_push) begin
      sp_d  = sp_q + PW'(1);
      cnt_d = ras_full ? cnt_q : cnt_q + CW'(1);
    end else if (commit_pop) begin
      sp_d  = sp_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  // RAS storage and pointers; the write slot is the current stack pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ras_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      if (commit_push) ras_q[sp_q] <= ret_addr_q;
    end
  end

  assign top_idx     = sp_q - PW'(1);
  assign top_address = ras_empty ? '0 : ras_q[top_idx];

  // Sticky underflow flag; a new error in the same cycle as clr_err wins.
  always_comb begin
    err_unf_d = clr_err ? 1'b0 : err_unf_q;
    if (unf_hit) err_unf_d = 1'b1;
  end

  // Underflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_unf_q <= 1'b0;
    else        err_unf_q <= err_unf_d;
  end

  assign err_unf = err_unf_q;

`ifdef PCSEQ_RAS_WRAP_EN
  assign err_ovf = 1'b0;
`else
  logic err_ovf_q, err_ovf_d;

  // Sticky overflow flag; a new error in the same cycle as clr_err wins.
  always_comb begin
    err_ovf_d = clr_err ? 1'b0 : err_ovf_q;
    if (ovf_hit) err_ovf_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_ovf_q <= 1'b0;
    else        err_ovf_q <= err_ovf_d;
  end

  assign err_ovf = err_ovf_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model of the RAS.
module tb_pc_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            upd_req = 0, is_jump = 0, is_call = 0, is_ret = 0, br_taken = 0, clr_err = 0;
  logic [AW-1:0]   pc_cur = '0;
  logic [1:0]      pc_src;
  logic            pc_write;
  logic [AW-1:0]   top_address;
  logic            busy;
  logic [CW-1:0]   ras_count;
  logic            ras_full, ras_empty, err_ovf, err_unf;
  logic [1:0]      dbg_state;

  pc_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .upd_req(upd_req), .is_jump(is_jump), .is_call(is_call),
    .is_ret(is_ret), .br_taken(br_taken), .pc_cur(pc_cur), .clr_err(clr_err),
    .pc_src(pc_src), .pc_write(pc_write), .top_address(top_address), .busy(busy),
    .ras_count(ras_count), .ras_full(ras_full), .ras_empty(ras_empty),
    .err_ovf(err_ovf), .err_unf(err_unf), .dbg_state(dbg_state)
  );

`ifdef PCSEQ_RAS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q is the return-address stack: back = top. mode: 0 ready, 1 strobing, 2 halted.
  logic [AW-1:0] exp_q[$];
  int            m_mode = 0;
  logic [1:0]    m_src = 2'b00;
  int            m_act = 0;          // 0 none, 1 push, 2 pop
  logic [AW-1:0] m_addr = '0;
  bit            m_ovf = 0, m_unf = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_mode = 0; m_src = 2'b00; m_act = 0; m_addr = '0; m_ovf = 0; m_unf = 0;
    end else begin
      bit clr;
      clr = clr_err;
      if (clr) begin m_ovf = 0; m_unf = 0; end
      case (m_mode)
        1: begin
          if (m_act == 1) begin
            if (exp_q.size() == DEPTH) void'(exp_q.pop_front());
            exp_q.push_back(m_addr);
          end else if (m_act == 2) begin
            void'(exp_q.pop_back());
          end
          m_mode = 0;
        end
        2: if (clr) m_mode = 0;
        default: if (upd_req) begin
          if (is_ret) begin m_src = 2'b11; m_act = 2; end
          else if (is_call) begin m_src = 2'b01; m_act = 1; end
          else if (is_jump) begin m_src = 2'b01; m_act = 0; end
          else if (br_taken) begin m_src = 2'b10; m_act = 0; end
          else begin m_src = 2'b00; m_act = 0; end
          m_addr = pc_cur + 1;
          if (m_act == 2 && exp_q.size() == 0) begin m_mode = 2; m_unf = 1; end
          else if (m_act == 1 && exp_q.size() == DEPTH && !WRAP) begin m_mode = 2; m_ovf = 1; end
          else m_mode = 1;
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en && rst_n) begin
      int sz;
      sz = exp_q.size();
      chk("pc_write", pc_write, (m_mode == 1));
      if (m_mode == 1) chk("pc_src", pc_src, m_src);
      chk("busy", busy, (m_mode != 0));
      chk("ras_count", ras_count, sz);
      chk("top_address", top_address, (sz > 0) ? exp_q[sz-1] : '0);
      chk("ras_full", ras_full, (sz == DEPTH));
      chk("ras_empty", ras_empty, (sz == 0));
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_unf", err_unf, m_unf);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic j, input logic c, input logic r, input logic b,
                       input logic [AW-1:0] pc);
    upd_req = 1; is_jump = j; is_call = c; is_ret = r; br_taken = b; pc_cur = pc;
    @(negedge clk);
    upd_req = 0; is_jump = 0; is_call = 0; is_ret = 0; br_taken = 0;
  endtask

  task automatic pulse_clr();
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    check_en = 1;

    // reset state
    chk("rst pc_write", pc_write, 0);
    chk("rst busy", busy, 0);
    chk("rst ras_count", ras_count, 0);
    chk("rst top", top_address, 0);
    chk("rst errs", {err_ovf, err_unf}, 0);

    // sequential update: strobe one clock after the request, busy for one clock
    issue(0, 0, 0, 0, 32'h100);
    chk("seq pc_write", pc_write, 1);
    chk("seq pc_src", pc_src, 2'b00);
    chk("seq busy", busy, 1);
    @(negedge clk);
    chk("seq busy done", busy, 0);

    // plain jump and taken branch
    issue(1, 0, 0, 0, 32'h10); chk("jmp pc_src", pc_src, 2'b01); @(negedge clk);
    issue(0, 0, 0, 1, 32'h20); chk("br pc_src", pc_src, 2'b10); @(negedge clk);

    // CALL then RET
    issue(0, 1, 0, 0, 32'h40);
    chk("call pc_src", pc_src, 2'b01);
    @(negedge clk);
    chk("call top", top_address, 32'h41);
    chk("call count", ras_count, 1);
    issue(0, 0, 1, 0, 32'h90);
    chk("ret pc_src", pc_src, 2'b11);
    chk("ret top", top_address, 32'h41);
    @(negedge clk);
    chk("ret empty", ras_empty, 1);

    // RET priority with several flags set
    issue(0, 1, 0, 0, 32'h40); @(negedge clk);
    issue(0, 1, 1, 1, 32'h80);
    chk("prio pc_src", pc_src, 2'b11);
    @(negedge clk);
    chk("prio count", ras_count, 0);

    // return address wraps modulo 2^AW
    issue(0, 1, 0, 0, 32'hFFFF_FFFF); @(negedge clk);
    chk("wrap addr count", ras_count, 1);
    chk("wrap addr top", top_address, 0);
    issue(0, 0, 1, 0, 32'h0); @(negedge clk);

    // nine CALLs into an eight-deep stack
    for (int i = 0; i < 8; i++) begin
      issue(0, 1, 0, 0, 32'h200 + i * 4); @(negedge clk);
    end
    chk("full flag", ras_full, 1);
    issue(0, 1, 0, 0, 32'h200 + 8 * 4);
    if (WRAP) begin
      chk("9th pc_write", pc_write, 1);
      @(negedge clk);
      chk("9th count", ras_count, 8);
      chk("9th top", top_address, 32'h221);
      for (int k = 0; k < 8; k++) begin
        issue(0, 0, 1, 0, 32'h0);
        chk("wrap ret top", top_address, 32'h200 + (8 - k) * 4 + 1);
        @(negedge clk);
      end
    end else begin
      chk("9th pc_write", pc_write, 0);
      chk("9th busy", busy, 1);
      chk("9th err_ovf", err_ovf, 1);
      chk("9th count", ras_count, 8);
      pulse_clr();
      chk("ovf cleared", err_ovf, 0);
      chk("ovf idle", busy, 0);
      for (int k = 0; k < 8; k++) begin
        issue(0, 0, 1, 0, 32'h0);
        chk("ret top", top_address, 32'h200 + (7 - k) * 4 + 1);
        @(negedge clk);
      end
    end
    chk("drained", ras_empty, 1);

    // RET on empty stack: halt, ignore requests, recover with clr_err
    issue(0, 0, 1, 0, 32'h300);
    chk("unf pc_write", pc_write, 0);
    chk("unf busy", busy, 1);
    chk("unf flag", err_unf, 1);
    issue(0, 0, 0, 0, 32'h304);
    chk("halt ignores req", pc_write, 0);
    chk("halt busy", busy, 1);
    pulse_clr();
    chk("unf cleared", err_unf, 0);
    chk("unf idle", busy, 0);
    issue(0, 0, 0, 0, 32'h308);
    chk("after clr pc_write", pc_write, 1);
    @(negedge clk);

    // reset in the middle of an UPDATE aborts the push
    upd_req = 1; is_call = 1; pc_cur = 32'h500;
    @(posedge clk);
    #1 rst_n = 0;
    upd_req = 0; is_call = 0;
    @(negedge clk);
    chk("midrst pc_write", pc_write, 0);
    chk("midrst count", ras_count, 0);
    chk("midrst top", top_address, 0);
    rst_n = 1;
    @(negedge clk);

    // randomized phase, checked by the per-cycle compare
    for (int n = 0; n < 3000; n++) begin
      upd_req  = ($urandom_range(0, 1) == 1);
      is_jump  = ($urandom_range(0, 3) == 0);
      is_call  = ($urandom_range(0, 2) == 0);
      is_ret   = ($urandom_range(0, 3) == 0);
      br_taken = ($urandom_range(0, 3) == 0);
      clr_err  = ($urandom_range(0, 9) == 0);
      pc_cur   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      @(negedge clk);
    end
    upd_req = 0; is_jump = 0; is_call = 0; is_ret = 0; br_taken = 0; clr_err = 0;
    @(negedge clk);

    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
